// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the multi-port RISC-V register file.
// Holds the clear-FSM state type, the x0 address and the write-port priority select.
package riscv_rf_pkg;

    typedef enum logic {
        IDLE,
        SWEEP
    } clr_state_t;

    typedef enum logic [1:0] {
        WSEL_NONE,
        WSEL_P0,
        WSEL_P1
    } wsel_t;

    localparam int unsigned REG_ZERO = 0;

    // Port 1 is the younger writeback, so it wins an address collision.
    function automatic wsel_t write_sel(input logic hit0, input logic hit1);
        if (hit1) return WSEL_P1;
        if (hit0) return WSEL_P0;
        return WSEL_NONE;
    endfunction

endpackage

// File: rtl/riscv_regfile_mp_if.sv
// Bus bundle for riscv_regfile_mp: writeback ports, read ports, scoreboard and clear control.
// master drives requests (decode/writeback side); slave is the register file.
interface riscv_regfile_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [NREG-1:0]     busy_vec;
    logic                clr_req;
    logic                clr_busy;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output raddr, sb_set, sb_addr, clr_req,
        input  rdata, busy_vec, clr_busy
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  raddr, sb_set, sb_addr, clr_req,
        output rdata, busy_vec, clr_busy
    );

endinterface

// File: rtl/riscv_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared by writeback or sweep.
// A new issue to a register beats any clear of that register in the same cycle.
module riscv_rf_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr0,
    input  logic [AW-1:0]   clr0_addr,
    input  logic            clr1,
    input  logic [AW-1:0]   clr1_addr,
    input  logic            set,
    input  logic [AW-1:0]   set_addr,
    input  logic            sweep,
    input  logic [AW-1:0]   sweep_addr,
    output logic [NREG-1:0] busy_vec
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec[0] <= 1'b0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (set && set_addr == AW'(i))
                    busy_vec[i] <= 1'b1;
                else if ((clr0 && clr0_addr == AW'(i)) ||
                         (clr1 && clr1_addr == AW'(i)) ||
                         (sweep && sweep_addr == AW'(i)))
                    busy_vec[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Dual-writeback, multi-read RISC-V integer register file with bypass,
// pending-write scoreboard and a one-register-per-cycle context-clear sweep.
module riscv_regfile_mp
    import riscv_rf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    riscv_regfile_mp_if.slave bus
);

    localparam int unsigned   AW     = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
    localparam logic [AW-1:0] ONE_A  = AW'(1);
    localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);

    clr_state_t      state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic            sweeping;
    logic            wq0, wq1;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    assign sweeping     = (state == SWEEP);
    assign bus.clr_busy = sweeping;
    // Writes are dropped during the sweep, which also disables bypass then.
    assign wq0 = bus.we0 && (bus.waddr0 != ZERO_A) && !sweeping;
    assign wq1 = bus.we1 && (bus.waddr1 != ZERO_A) && !sweeping;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= ONE_A;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = SWEEP;
                    idx_nxt   = ONE_A;
                end
            end
            SWEEP: begin
                if (idx == LAST_A) begin
                    state_nxt = IDLE;
                    idx_nxt   = ONE_A;
                end else begin
                    idx_nxt = idx + ONE_A;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = ONE_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (sweeping && idx == AW'(i)) begin
                    regs[i] <= '0;
                end else begin
                    case (write_sel(wq0 && bus.waddr0 == AW'(i), wq1 && bus.waddr1 == AW'(i)))
                        WSEL_P1: regs[i] <= bus.wdata1;
                        WSEL_P0: regs[i] <= bus.wdata0;
                        default: regs[i] <= regs[i];
                    endcase
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        ra        = '0;
        rd        = '0;
        bus.rdata = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = bus.raddr[k*AW +: AW];
            rd = regs[ra];
            if (BYPASS != 0) begin
                case (write_sel(wq0 && bus.waddr0 == ra, wq1 && bus.waddr1 == ra))
                    WSEL_P1: rd = bus.wdata1;
                    WSEL_P0: rd = bus.wdata0;
                    default: rd = regs[ra];
                endcase
            end
            if (ra == ZERO_A)
                rd = '0;
            bus.rdata[k*XLEN +: XLEN] = rd;
        end
    end

    riscv_rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr0       (wq0),
        .clr0_addr  (bus.waddr0),
        .clr1       (wq1),
        .clr1_addr  (bus.waddr1),
        .set        (bus.sb_set && bus.sb_addr != ZERO_A),
        .set_addr   (bus.sb_addr),
        .sweep      (sweeping),
        .sweep_addr (idx),
        .busy_vec   (busy)
    );

    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp: a BYPASS=1 and a BYPASS=0 instance driven with
// identical stimulus, compared against hand-computed expectations.
module tb_riscv_regfile_mp;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_a ();
    riscv_regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_b ();

    riscv_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    riscv_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        ss;
        logic [4:0]  sa;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e0n;
        logic [31:0] e1n;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic ss, input logic [4:0] sa, input logic cr);
        bus_a.we0 = we0; bus_a.waddr0 = a0; bus_a.wdata0 = d0;
        bus_a.we1 = we1; bus_a.waddr1 = a1; bus_a.wdata1 = d1;
        bus_a.raddr = {r1, r0}; bus_a.sb_set = ss; bus_a.sb_addr = sa; bus_a.clr_req = cr;
        bus_b.we0 = we0; bus_b.waddr0 = a0; bus_b.wdata0 = d0;
        bus_b.we1 = we1; bus_b.waddr1 = a1; bus_b.wdata1 = d1;
        bus_b.raddr = {r1, r0}; bus_b.sb_set = ss; bus_b.sb_addr = sa; bus_b.clr_req = cr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            drive(1, 5'(i), base | 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        idle();
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            bus_a.raddr = {5'(31 - a), 5'(a)};
            bus_b.raddr = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("%s a r%0d", tag, a), bus_a.rdata[31:0], 32'h0);
            chk($sformatf("%s a r%0d", tag, 31 - a), bus_a.rdata[63:32], 32'h0);
            chk($sformatf("%s b r%0d", tag, a), bus_b.rdata[31:0], 32'h0);
            chk($sformatf("%s b r%0d", tag, 31 - a), bus_b.rdata[63:32], 32'h0);
        end
        bus_a.raddr = '0;
        bus_b.raddr = '0;
    endtask

    task automatic pulse_clr();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (bus_a.clr_busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n_high;

        tv[0]  = '{1, 1, 32'h11, 0, 0, 0, 1, 0, 0, 0, 32'h11, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 32'h11, 0, 32'h11, 0, 0};
        tv[2]  = '{1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 1, 0, 0, 32'h11, 0, 32'h11, 0};
        tv[3]  = '{1, 5, 32'h1111, 1, 5, 32'h2222, 5, 5, 0, 0, 32'h2222, 32'h2222, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 32'h2222, 32'h11, 32'h2222, 32'h11, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 0, 0, 0, 0, 32'h80};
        tv[6]  = '{1, 7, 32'h77, 0, 0, 0, 7, 5, 0, 0, 32'h77, 32'h2222, 0, 32'h2222, 0};
        tv[7]  = '{0, 0, 0, 1, 7, 32'h78, 7, 0, 1, 7, 32'h78, 0, 32'h77, 0, 32'h80};
        tv[8]  = '{1, 10, 32'hAA, 1, 9, 32'h99, 9, 10, 1, 9, 32'h99, 32'hAA, 0, 0, 32'h280};
        tv[9]  = '{1, 9, 32'h9A, 0, 0, 0, 9, 7, 0, 0, 32'h9A, 32'h78, 32'h99, 32'h78, 32'h80};
        tv[10] = '{1, 31, 32'hFFFF_FFFF, 0, 0, 0, 31, 10, 0, 0, 32'hFFFF_FFFF, 32'hAA, 0, 32'hAA, 32'h80};
        tv[11] = '{1, 3, 32'h33, 1, 4, 32'h44, 3, 4, 0, 0, 32'h33, 32'h44, 0, 0, 32'h80};

        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset clears a populated file and scoreboard.
        fill(32'h0000_0100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0);
        step();
        idle();
        bus_a.raddr = {5'd0, 5'd17};
        bus_b.raddr = {5'd0, 5'd17};
        #1;
        chk("prefill r17 a", bus_a.rdata[31:0], 32'h111);
        chk("prefill r17 b", bus_b.rdata[31:0], 32'h111);
        chk("prefill busy a", bus_a.busy_vec, 32'h0010_0000);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset busy a", bus_a.busy_vec, 32'h0);
        chk("reset busy b", bus_b.busy_vec, 32'h0);
        chk("reset clr_busy a", 32'(bus_a.clr_busy), 32'h0);
        chk("reset clr_busy b", 32'(bus_b.clr_busy), 32'h0);
        read_all_zero("reset");

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].we0, tv[i].a0, tv[i].d0, tv[i].we1, tv[i].a1, tv[i].d1,
                  tv[i].r0, tv[i].r1, tv[i].ss, tv[i].sa, 0);
            @(negedge clk);
            chk($sformatf("v%0d rd0 byp", i), bus_a.rdata[31:0], tv[i].e0);
            chk($sformatf("v%0d rd1 byp", i), bus_a.rdata[63:32], tv[i].e1);
            chk($sformatf("v%0d rd0 nobyp", i), bus_b.rdata[31:0], tv[i].e0n);
            chk($sformatf("v%0d rd1 nobyp", i), bus_b.rdata[63:32], tv[i].e1n);
            step();
            chk($sformatf("v%0d busy a", i), bus_a.busy_vec, tv[i].ebusy);
            chk($sformatf("v%0d busy b", i), bus_b.busy_vec, tv[i].ebusy);
        end
        idle();

        // Context clear with a dropped write, an ignored re-request and a mid-sweep issue.
        fill(32'hA500_0000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 0);
        step();
        idle();
        chk("pre-clear busy", bus_a.busy_vec, 32'h4000_0010);
        chk("pre-clear clr_busy", 32'(bus_a.clr_busy), 32'h0);
        pulse_clr();
        n_high = 0;
        while (bus_a.clr_busy && n_high < 100) begin
            n_high++;
            if (n_high == 5)  drive(1, 3, 32'h333, 0, 0, 0, 3, 31, 0, 0, 0);
            if (n_high == 10) drive(0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 1);
            if (n_high == 20) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
            @(negedge clk);
            if (n_high == 5) begin
                chk("sweep r3 no bypass a", bus_a.rdata[31:0], 32'h0);
                chk("sweep r3 no bypass b", bus_b.rdata[31:0], 32'h0);
                chk("sweep r31 unswept", bus_a.rdata[63:32], 32'hA500_001F);
            end
            if (n_high == 10)
                chk("sweep clr_busy b", 32'(bus_b.clr_busy), 32'h1);
            step();
            idle();
        end
        chk("sweep length", 32'(n_high), 32'd31);
        chk("post-sweep clr_busy b", 32'(bus_b.clr_busy), 32'h0);
        chk("post-sweep busy a", bus_a.busy_vec, 32'h0000_0004);
        chk("post-sweep busy b", bus_b.busy_vec, 32'h0000_0004);
        step();
        chk("no restart clr_busy", 32'(bus_a.clr_busy), 32'h0);
        read_all_zero("sweep");

        // Reset during the sweep aborts it; a later request sweeps the full range again.
        fill(32'h5A00_0000);
        pulse_clr();
        chk("abort sweep started", 32'(bus_a.clr_busy), 32'h1);
        repeat (9) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("abort clr_busy a", 32'(bus_a.clr_busy), 32'h0);
        chk("abort clr_busy b", 32'(bus_b.clr_busy), 32'h0);
        read_all_zero("abort");
        pulse_clr();
        count_sweep(n_high);
        chk("fresh sweep length", 32'(n_high), 32'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
